// File: rtl/mux21_rr_arbiter.sv
// Round-robin arbiter between two valid/ready sources feeding a one-entry
// registered output stage; S reports which source the held word came from.
module mux21_rr_arbiter #(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             V0,
  input  logic [WIDTH-1:0] D0,
  output logic             R0,
  input  logic             V1,
  input  logic [WIDTH-1:0] D1,
  output logic             R1,
  output logic [WIDTH-1:0] Y,
  output logic             YV,
  input  logic             YR,
  output logic             S
);

  logic [WIDTH-1:0] y_q, y_d;
  logic             yv_q, yv_d;
  logic             s_q, s_d;
  logic             last_q, last_d;
  logic             le;
  logic             g0;
  logic             g1;

  // Output stage can take a word when empty or when its word leaves this cycle
  assign le = !yv_q | YR;

  assign g0 = V0 & (!V1 | last_q);
  assign g1 = V1 & (!V0 | !last_q);

  // Readiness ignores a source's own valid so it never forms a valid->ready loop
  assign R0 = le & (!V1 | last_q);
  assign R1 = le & (!V0 | !last_q);

  always_comb begin
    y_d    = y_q;
    yv_d   = yv_q;
    s_d    = s_q;
    last_d = last_q;
    if (le) begin
      if (g0) begin
        y_d    = D0;
        s_d    = 1'b0;
        last_d = 1'b0;
        yv_d   = 1'b1;
      end else if (g1) begin
        y_d    = D1;
        s_d    = 1'b1;
        last_d = 1'b1;
        yv_d   = 1'b1;
      end else begin
        yv_d   = 1'b0;
      end
    end
  end

  // LAST resets to 1 so that D0 wins the first contended cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      y_q    <= '0;
      yv_q   <= 1'b0;
      s_q    <= 1'b0;
      last_q <= 1'b1;
    end else begin
      y_q    <= y_d;
      yv_q   <= yv_d;
      s_q    <= s_d;
      last_q <= last_d;
    end
  end

  assign Y  = y_q;
  assign YV = yv_q;
  assign S  = s_q;

endmodule
